// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared FSM states, default strobe timing and phase helpers
// for the RTC multiplexed-bus read controller.
package rtc_bus_pkg;

    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 8;
    localparam int T_HOLD_DEF  = 2;

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_PULSE,
        A_HOLD,
        D_SETUP,
        D_PULSE,
        D_HOLD,
        DONE
    } state_t;

    function automatic logic is_addr(state_t s);
        return s inside {A_SETUP, A_PULSE, A_HOLD};
    endfunction

    function automatic logic is_data(state_t s);
        return s inside {D_SETUP, D_PULSE, D_HOLD};
    endfunction

    function automatic logic is_timed(state_t s);
        return is_addr(s) || is_data(s);
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable down-counter; tc pulses on the last cycle of a
// phase of 'value' cycles that starts on the cycle after load.
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] value,
    output logic       tc
);

    logic [3:0] cnt;
    logic       armed;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= 4'd0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= value - 4'd1;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == 4'd0) armed <= 1'b0;
            else             cnt   <= cnt - 4'd1;
        end
    end

    assign tc = armed && (cnt == 4'd0);

endmodule

// File: rtl/rtc_read_ctrl.sv
// rtc_read_ctrl: single-register read over a multiplexed RTC AD bus.
// Define RTC_READ_BCD_CHECK_EN to flag non-BCD bytes on bcd_err.
module rtc_read_ctrl #(
    parameter int T_SETUP = rtc_bus_pkg::T_SETUP_DEF,
    parameter int T_PULSE = rtc_bus_pkg::T_PULSE_DEF,
    parameter int T_HOLD  = rtc_bus_pkg::T_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out,
    output logic       bcd_err,
    output logic       rtc_cs_n,
    output logic       rtc_wr_n,
    output logic       rtc_rd_n,
    output logic       rtc_ad,
    output logic [7:0] rtc_bus_out,
    output logic       rtc_bus_oe,
    input  logic [7:0] rtc_bus_in
);

    import rtc_bus_pkg::*;

    state_t     state, nxt;
    logic [7:0] addr_q, rd_data;
    logic [3:0] len;
    logic       load, tc;

    always_comb begin
        nxt = state;
        if (state == IDLE)      nxt = start ? A_SETUP : IDLE;
        else if (state == DONE) nxt = IDLE;
        else if (tc)            nxt = state_t'(state + 3'd1);
    end

    always_comb begin
        len  = (nxt == A_SETUP || nxt == D_SETUP) ? 4'(T_SETUP) :
               (nxt == A_PULSE || nxt == D_PULSE) ? 4'(T_PULSE) : 4'(T_HOLD);
        load = (nxt != state) && is_timed(nxt);
    end

    rtc_phase_timer u_timer (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .value(len),
        .tc   (tc)
    );

    // Bus outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            addr_q      <= 8'h00;
            rd_data     <= 8'h00;
            data_out    <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            rtc_cs_n    <= 1'b1;
            rtc_wr_n    <= 1'b1;
            rtc_rd_n    <= 1'b1;
            rtc_ad      <= 1'b1;
            rtc_bus_oe  <= 1'b0;
            rtc_bus_out <= 8'h00;
        end else begin
            state <= nxt;
            if (state == IDLE && start) addr_q <= addr;
            if (state == D_PULSE && tc) rd_data <= rtc_bus_in;
            if (state == DONE) data_out <= rd_data;
            busy        <= is_timed(state);
            done        <= state == DONE;
            rtc_cs_n    <= !is_timed(state);
            rtc_wr_n    <= state != A_PULSE;
            rtc_rd_n    <= state != D_PULSE;
            rtc_ad      <= !is_data(state);
            rtc_bus_oe  <= is_addr(state);
            rtc_bus_out <= is_addr(state) ? addr_q : 8'h00;
        end
    end

`ifdef RTC_READ_BCD_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) bcd_err <= 1'b0;
        else        bcd_err <= (state == DONE) && (rd_data[7:4] > 4'd9 || rd_data[3:0] > 4'd9);
    end
`else
    assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_read_ctrl.sv
// tb_rtc_read_ctrl: table-driven and randomized checks of rtc_read_ctrl
// against an RTC register-file model that answers on the AD bus.
module tb_rtc_read_ctrl;

`ifdef RTC_READ_BCD_CHECK_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif
    localparam int PHASE = 2 + 8 + 2;
    localparam int LAT   = 2 * PHASE + 1;

    logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [7:0] addr = 8'h00, rtc_bus_in = 8'h00;
    logic       busy, done, bcd_err, rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_ad, rtc_bus_oe;
    logic [7:0] data_out, rtc_bus_out;

    rtc_read_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr),
        .busy(busy), .done(done), .data_out(data_out), .bcd_err(bcd_err),
        .rtc_cs_n(rtc_cs_n), .rtc_wr_n(rtc_wr_n), .rtc_rd_n(rtc_rd_n), .rtc_ad(rtc_ad),
        .rtc_bus_out(rtc_bus_out), .rtc_bus_oe(rtc_bus_oe), .rtc_bus_in(rtc_bus_in)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int overlap = 0, oe_rd = 0, cyc = 0;
    logic [7:0] regs [256];
    logic [7:0] lat_a = 8'h00;
    logic [7:0] last_data = 8'h00;

    // RTC model: latches the address while wr_n is low, returns its register while rd_n is low.
    always @(negedge clk) begin
        if (!rtc_wr_n) lat_a = rtc_bus_out;
        rtc_bus_in = !rtc_rd_n ? regs[lat_a] : 8'($urandom);
        if (!rtc_wr_n && !rtc_rd_n) overlap++;
        if (rtc_bus_oe && !rtc_rd_n) oe_rd++;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic bit bcd_bad(input logic [7:0] d);
        return BCD_EN && (d[7:4] > 4'd9 || d[3:0] > 4'd9);
    endfunction

    // Issue one read from IDLE; returns at the negedge where done is seen.
    task automatic read_txn(input logic [7:0] a, input int pulse_at,
                            output int lat, output int wr_cnt, output int rd_cnt,
                            output int oe_cnt, output int bus_bad);
        start = 1'b1;
        addr  = a;
        @(posedge clk);
        lat = 0; wr_cnt = 0; rd_cnt = 0; oe_cnt = 0; bus_bad = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (lat == 0) start = 1'b0;
            if (lat == pulse_at) begin start = 1'b1; addr = ~a; end
            if (lat == pulse_at + 1) start = 1'b0;
            if (!rtc_wr_n) wr_cnt++;
            if (!rtc_rd_n) rd_cnt++;
            if (rtc_bus_oe) oe_cnt++;
            if (rtc_bus_oe && (rtc_bus_out !== a || rtc_ad !== 1'b1)) bus_bad++;
            if (lat == 1) check("busy_after_accept", busy, 1);
            if (lat == 24) check("data_hold", data_out, last_data);
            if (done) break;
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] val;
        logic [7:0] exp_data;
        bit         exp_bcd;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lat, wr_cnt, rd_cnt, oe_cnt, bus_bad, n_done, n_busy, w;
        int t_done[$];
        for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
        tbl[0] = '{8'h23, 8'h59, 8'h59, 1'b0};
        tbl[1] = '{8'h05, 8'h5A, 8'h5A, BCD_EN};
        tbl[2] = '{8'h7F, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{8'hC3, 8'h99, 8'h99, 1'b0};
        tbl[4] = '{8'h40, 8'hA9, 8'hA9, BCD_EN};
        tbl[5] = '{8'hFF, 8'hFF, 8'hFF, BCD_EN};

        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state",
              {busy, done, data_out, bcd_err, rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_ad, rtc_bus_oe, rtc_bus_out},
              {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("start_ignored_in_reset", busy, 0);

        for (int i = 0; i < 6; i++) begin
            regs[tbl[i].addr] = tbl[i].val;
            read_txn(tbl[i].addr, -10, lat, wr_cnt, rd_cnt, oe_cnt, bus_bad);
            check("latency", lat, LAT);
            check("wr_n_low_cycles", wr_cnt, 8);
            check("rd_n_low_cycles", rd_cnt, 8);
            check("addr_phase_cycles", oe_cnt, PHASE);
            check("addr_phase_bus", bus_bad, 0);
            check("data_out", data_out, tbl[i].exp_data);
            check("bcd_err", bcd_err, tbl[i].exp_bcd);
            check("busy_at_done", busy, 0);
            last_data = tbl[i].exp_data;
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end

        for (int i = 0; i < 12; i++) begin
            logic [7:0] a, d;
            a = 8'($urandom);
            d = regs[a];
            read_txn(a, -10, lat, wr_cnt, rd_cnt, oe_cnt, bus_bad);
            check("rand_latency", lat, LAT);
            check("rand_data_out", data_out, d);
            check("rand_bcd_err", bcd_err, bcd_bad(d));
            last_data = d;
        end

        regs[8'h88] = 8'h12;
        read_txn(8'h88, 10, lat, wr_cnt, rd_cnt, oe_cnt, bus_bad);
        check("ignore_latency", lat, LAT);
        check("ignore_addr_kept", data_out, 8'h12);
        last_data = 8'h12;
        n_done = 0; n_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        check("ignored_start_no_done", n_done, 0);
        check("ignored_start_no_busy", n_busy, 0);

        start = 1'b1;
        addr  = 8'h33;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (rtc_rd_n && w < 60) begin @(negedge clk); w++; end
        check("abort_reach_rd", rtc_rd_n, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("abort_outputs", {rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_ad, rtc_bus_oe, busy, done},
              7'b1111000);
        check("abort_data", data_out, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        last_data = 8'h00;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        regs[8'h10] = 8'h47;
        start = 1'b1;
        addr  = 8'h10;
        w = 0;
        while (t_done.size() < 3 && w < 120) begin
            @(negedge clk);
            w++;
            if (done) begin
                t_done.push_back(cyc);
                check("b2b_data", data_out, 8'h47);
            end
        end
        start = 1'b0;
        check("b2b_done_count", t_done.size(), 3);
        if (t_done.size() == 3) begin
            check("b2b_gap1", t_done[1] - t_done[0], LAT + 1);
            check("b2b_gap2", t_done[2] - t_done[1], LAT + 1);
        end
        repeat (40) @(negedge clk);
        check("wr_rd_overlap", overlap, 0);
        check("oe_during_rd", oe_rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rtc_read_ctrl.md
RTC_READ_CTRL -- requirements
Module: rtc_read_ctrl

Interface
REQ-001 SHALL have parameter T_SETUP, default 2: cycles from bus strobe-line setup to strobe fall (range 1-15).
REQ-002 SHALL have parameter T_PULSE, default 8: cycles the strobe is held low (range 1-15).
REQ-003 SHALL have parameter T_HOLD, default 2: cycles after strobe rise before the next phase (range 1-15).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request a register read; sampled only in IDLE.
REQ-007 SHALL have port addr  input  8  RTC register address; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse; data_out valid in the same cycle.
REQ-010 SHALL have port data_out  output  8  last value read; held until the next done.
REQ-011 SHALL have port bcd_err  output  1  BCD check flag, valid with done (see Configuration).
REQ-012 SHALL have ports rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_ad  output  1 each  RTC bus strobes; rtc_ad=1 address phase, 0 data phase.
REQ-013 SHALL have port rtc_bus_out  output  8  value driven onto the multiplexed AD bus.
REQ-014 SHALL have port rtc_bus_oe  output  1  tri-state enable for rtc_bus_out.
REQ-015 SHALL have port rtc_bus_in  input  8  value sampled from the AD bus.

Function
REQ-016 SHALL implement FSM states IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, DONE.
REQ-017 SHALL move IDLE->A_SETUP on the edge where start=1 and capture addr on that edge.
REQ-018 SHALL keep each SETUP, PULSE and HOLD state for exactly T_SETUP, T_PULSE and T_HOLD cycles respectively, then advance in the listed order.
REQ-019 SHALL drive the following in the address phase (A_*): rtc_cs_n=0, rtc_ad=1, rtc_bus_oe=1, rtc_bus_out=captured addr, rtc_wr_n=0 only in A_PULSE.
REQ-020 SHALL drive the following in the data phase (D_*): rtc_cs_n=0, rtc_ad=0, rtc_bus_oe=0, rtc_rd_n=0 only in D_PULSE.
REQ-021 SHALL register rtc_bus_in into data_out on the last cycle of D_PULSE, i.e. before rtc_rd_n rises.
REQ-022 SHALL spend one cycle in DONE with done=1 and busy=0, then return to IDLE.
REQ-023 SHALL assert done exactly 2*(T_SETUP+T_PULSE+T_HOLD)+1 cycles after the accepting edge (25 cycles with defaults).
REQ-024 SHALL ignore start while busy=1 or in DONE; no request is queued.
REQ-025 SHALL accept start in IDLE on the cycle directly after DONE (back-to-back reads allowed).
REQ-026 SHALL register all bus outputs, with no combinational path from start or addr to any rtc_* output.
REQ-027 SHALL never have rtc_wr_n and rtc_rd_n low in the same cycle.
REQ-028 SHALL keep rtc_bus_oe=0 on every cycle where rtc_rd_n=0.

Reset
REQ-029 SHALL, with reset=0 at a clock edge, enter IDLE and set: busy=0, done=0, data_out=0, bcd_err=0, rtc_cs_n=1, rtc_wr_n=1, rtc_rd_n=1, rtc_ad=1, rtc_bus_oe=0, rtc_bus_out=0.
REQ-030 SHALL abort any transaction in progress on reset, with no done pulse; start is ignored while reset=0.

Configuration
REQ-031 SHALL, with macro RTC_READ_BCD_CHECK_EN defined, set bcd_err=1 with done when either nibble of the sampled byte exceeds 9.
REQ-032 SHALL, without RTC_READ_BCD_CHECK_EN, tie bcd_err to 0 and include no check logic.

Structure
REQ-033 SHALL take its FSM state enumeration and default timing constants (2/8/2) from shared package rtc_bus_pkg.
REQ-034 SHALL count phase cycles in one sub-module, rtc_phase_timer: load value, decrement, and a terminal pulse on the last cycle.

Verification
REQ-035 Bench SHALL check: reset=0 for 3 cycles, then start with addr=0x23 -> rtc_bus_out=0x23 and rtc_ad=1 during A_*; wr_n low exactly 8 cycles; done 25 cycles after acceptance.
REQ-036 Bench SHALL check: rtc_bus_in=0x59 held during D_PULSE -> data_out=0x59 and bcd_err=0 at done.
REQ-037 Bench SHALL check: with RTC_READ_BCD_CHECK_EN defined, rtc_bus_in=0x5A -> bcd_err=1 at done; with the macro undefined -> bcd_err=0.
REQ-038 Bench SHALL check: start pulsed again at cycle 10 of a read -> ignored; exactly one done pulse.
REQ-039 Bench SHALL check: reset=0 asserted during D_PULSE -> next cycle shows all strobes high, rtc_bus_oe=0, busy=0, and no done pulse.
REQ-040 Bench SHALL check: start held high continuously -> consecutive reads with done pulses 26 cycles apart, and rd_n/wr_n never low together.
